// File: rtl/sdrc_bank_fsm_p.sv
// Per-bank SDRAM sequencer: tracks the open row and issues PRE/ACT/RD/WR to the transfer controller.
// b2r_ack and b2x_req are combinational from state; a command is held until x2b_ack (valid-ready style).
module sdrc_bank_fsm_p #(
  parameter int RA_W       = 13,
  parameter int CA_W       = 13,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 7,
  parameter int TW         = 4,
  parameter int PAGE_MODE  = 0,
  parameter int IDLE_CLOSE = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      r2b_req,
  input  logic                                      r2b_start,
  input  logic                                      r2b_last,
  input  logic                                      r2b_wrap,
  input  logic                                      r2b_write,
  input  logic                                      sdr_dma_last,
  input  logic [ID_W-1:0]                           r2b_req_id,
  input  logic [RA_W-1:0]                           r2b_raddr,
  input  logic [CA_W-1:0]                           r2b_caddr,
  input  logic [LEN_W-1:0]                          r2b_len,
  output logic                                      b2r_ack,
  output logic                                      b2x_req,
  output logic                                      b2x_start,
  output logic                                      b2x_last,
  output logic                                      b2x_wrap,
  output logic [ID_W-1:0]                           b2x_id,
  output logic [LEN_W-1:0]                          b2x_len,
  output logic [1:0]                                b2x_cmd,
  output logic [((RA_W > CA_W) ? RA_W : CA_W)-1:0]  b2x_addr,
  input  logic                                      x2b_ack,
  input  logic                                      x2b_refresh,
  input  logic                                      x2b_pre_ok,
  input  logic                                      x2b_act_ok,
  input  logic                                      x2b_rdok,
  input  logic                                      x2b_wrok,
  input  logic                                      xfr_ok,
  input  logic [TW-1:0]                             tras_delay,
  input  logic [TW-1:0]                             trp_delay,
  input  logic [TW-1:0]                             trcd_delay,
  output logic                                      tras_ok,
  output logic                                      bank_valid,
  output logic [RA_W-1:0]                           bank_row
);

  localparam int AW   = (RA_W > CA_W) ? RA_W : CA_W;
  localparam int IC_W = (IDLE_CLOSE > 1) ? $clog2(IDLE_CLOSE + 1) : 1;

  localparam logic [1:0] OP_PRE = 2'd0;
  localparam logic [1:0] OP_ACT = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_WR  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_XFR, S_CLOSE} state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     tras_cnt;
  logic [IC_W-1:0]   idle_cnt;
  logic [ID_W-1:0]   l_id;
  logic [RA_W-1:0]   l_raddr;
  logic [CA_W-1:0]   l_caddr;
  logic [LEN_W-1:0]  l_len;
  logic              l_start, l_last, l_wrap, l_write, l_dma_last;

  logic              page_hit, timer_zero, pre_rdy, idle_expire, in_idle;
  logic [AW-1:0]     row_ext, col_ext, pre_addr;

  assign in_idle    = (state == S_IDLE);
  assign page_hit   = bank_valid & (r2b_raddr == bank_row);
  assign timer_zero = (timer == '0);
  assign tras_ok    = (tras_cnt == '0);
  assign pre_rdy    = tras_ok & x2b_pre_ok & timer_zero;
  assign b2r_ack    = in_idle & r2b_req;
  assign idle_expire = (IDLE_CLOSE > 0) && in_idle && !r2b_req && !x2b_refresh && bank_valid
                       && (idle_cnt == IC_W'(IDLE_CLOSE - 1));

  assign row_ext  = AW'(l_raddr);
  assign col_ext  = AW'(l_caddr);
  // A10 low selects a single-bank precharge
  assign pre_addr = row_ext & ~(AW'(1) << 10);

  assign b2x_id    = in_idle ? r2b_req_id : l_id;
  assign b2x_len   = in_idle ? r2b_len    : l_len;
  assign b2x_start = in_idle ? r2b_start  : l_start;
  assign b2x_last  = in_idle ? r2b_last   : l_last;
  assign b2x_wrap  = in_idle ? r2b_wrap   : l_wrap;

  always_comb begin
    b2x_req  = 1'b0;
    b2x_cmd  = OP_PRE;
    b2x_addr = '0;
    case (state)
      S_PRE, S_CLOSE: begin
        b2x_req  = pre_rdy;
        b2x_addr = pre_addr;
      end
      S_ACT: begin
        b2x_req  = timer_zero & x2b_act_ok;
        b2x_cmd  = OP_ACT;
        b2x_addr = row_ext;
      end
      S_XFR: begin
        b2x_req  = timer_zero & xfr_ok & (l_write ? x2b_wrok : x2b_rdok);
        b2x_cmd  = l_write ? OP_WR : OP_RD;
        b2x_addr = col_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      tras_cnt   <= '0;
      idle_cnt   <= '0;
      bank_valid <= 1'b0;
      bank_row   <= '0;
      l_id       <= '0;
      l_raddr    <= '0;
      l_caddr    <= '0;
      l_len      <= '0;
      l_start    <= 1'b0;
      l_last     <= 1'b0;
      l_wrap     <= 1'b0;
      l_write    <= 1'b0;
      l_dma_last <= 1'b0;
    end else begin
      if (!timer_zero) timer    <= timer - 1'b1;
      if (!tras_ok)    tras_cnt <= tras_cnt - 1'b1;
      idle_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (r2b_req) begin
            l_id       <= r2b_req_id;
            l_raddr    <= r2b_raddr;
            l_caddr    <= r2b_caddr;
            l_len      <= r2b_len;
            l_start    <= r2b_start;
            l_last     <= r2b_last;
            l_wrap     <= r2b_wrap;
            l_write    <= r2b_write;
            l_dma_last <= sdr_dma_last;
            // refresh closes every row, so the request must re-activate
            if (x2b_refresh)     state <= S_ACT;
            else if (page_hit)   state <= S_XFR;
            else if (bank_valid) state <= S_PRE;
            else                 state <= S_ACT;
          end else if (idle_expire) begin
            state <= S_CLOSE;
          end else if ((IDLE_CLOSE > 0) && bank_valid && !x2b_refresh) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_PRE: begin
          if (x2b_ack) begin
            timer      <= trp_delay;
            bank_valid <= 1'b0;
            state      <= S_ACT;
          end
          if (x2b_refresh) state <= S_ACT;
        end
        S_ACT: begin
          if (x2b_ack) begin
            timer    <= trcd_delay;
            tras_cnt <= tras_delay;
            // an activate crossing a refresh is lost; stay here and reissue it
            if (!x2b_refresh) begin
              bank_valid <= 1'b1;
              bank_row   <= l_raddr;
              state      <= S_XFR;
            end
          end
        end
        S_XFR: begin
          if (x2b_ack)          state <= (l_dma_last || (PAGE_MODE != 0)) ? S_CLOSE : S_IDLE;
          else if (x2b_refresh) state <= S_ACT;
        end
        S_CLOSE: begin
          if (x2b_ack) begin
            timer      <= trp_delay;
            bank_valid <= 1'b0;
            state      <= S_IDLE;
          end else if (x2b_refresh) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (x2b_refresh) bank_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdrc_bank_fsm_p.sv
// Bench for sdrc_bank_fsm_p: three instances (open-page, closed-page, idle-close=8) share stimulus;
// one is selected per scenario and its command stream is checked against an expected-command queue.
`timescale 1ns/1ps
module tb_sdrc_bank_fsm_p;

  localparam int RA_W = 13, CA_W = 13, ID_W = 4, LEN_W = 7, TW = 4, AW = 13;
  localparam logic [1:0] OP_PRE = 2'd0, OP_ACT = 2'd1, OP_RD = 2'd2, OP_WR = 2'd3;

  logic clk = 1'b0;
  logic reset;
  logic r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write, sdr_dma_last;
  logic [ID_W-1:0]  r2b_req_id;
  logic [RA_W-1:0]  r2b_raddr;
  logic [CA_W-1:0]  r2b_caddr;
  logic [LEN_W-1:0] r2b_len;
  logic x2b_refresh, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok;
  logic [TW-1:0] tras_delay, trp_delay, trcd_delay;
  logic auto_ack;

  logic [2:0]       b2r_ack_w, b2x_req_w, b2x_start_w, b2x_last_w, b2x_wrap_w;
  logic [2:0]       x2b_ack_w, tras_ok_w, bank_valid_w;
  logic [ID_W-1:0]  b2x_id_w   [3];
  logic [LEN_W-1:0] b2x_len_w  [3];
  logic [1:0]       b2x_cmd_w  [3];
  logic [AW-1:0]    b2x_addr_w [3];
  logic [RA_W-1:0]  bank_row_w [3];

  // controller model: accepts any command the cycle it is requested
  assign x2b_ack_w = {3{auto_ack}} & b2x_req_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdrc_bank_fsm_p #(
      .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .LEN_W(LEN_W), .TW(TW),
      .PAGE_MODE((g == 1) ? 1 : 0), .IDLE_CLOSE((g == 2) ? 8 : 0)
    ) u_dut (
      .clk(clk), .reset(reset),
      .r2b_req(r2b_req), .r2b_start(r2b_start), .r2b_last(r2b_last), .r2b_wrap(r2b_wrap),
      .r2b_write(r2b_write), .sdr_dma_last(sdr_dma_last),
      .r2b_req_id(r2b_req_id), .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
      .b2r_ack(b2r_ack_w[g]), .b2x_req(b2x_req_w[g]), .b2x_start(b2x_start_w[g]),
      .b2x_last(b2x_last_w[g]), .b2x_wrap(b2x_wrap_w[g]), .b2x_id(b2x_id_w[g]),
      .b2x_len(b2x_len_w[g]), .b2x_cmd(b2x_cmd_w[g]), .b2x_addr(b2x_addr_w[g]),
      .x2b_ack(x2b_ack_w[g]), .x2b_refresh(x2b_refresh), .x2b_pre_ok(x2b_pre_ok),
      .x2b_act_ok(x2b_act_ok), .x2b_rdok(x2b_rdok), .x2b_wrok(x2b_wrok), .xfr_ok(xfr_ok),
      .tras_delay(tras_delay), .trp_delay(trp_delay), .trcd_delay(trcd_delay),
      .tras_ok(tras_ok_w[g]), .bank_valid(bank_valid_w[g]), .bank_row(bank_row_w[g])
    );
  end

  logic [1:0]       sel;
  logic             s_ack, s_req, s_xack, s_tras_ok, s_bv;
  logic [2:0]       s_qual;
  logic [1:0]       s_cmd;
  logic [AW-1:0]    s_addr;
  logic [RA_W-1:0]  s_row;
  logic [ID_W-1:0]  s_id;
  logic [LEN_W-1:0] s_len;

  always_comb begin
    s_ack     = b2r_ack_w[sel];
    s_req     = b2x_req_w[sel];
    s_xack    = x2b_ack_w[sel];
    s_tras_ok = tras_ok_w[sel];
    s_bv      = bank_valid_w[sel];
    s_qual    = {b2x_start_w[sel], b2x_last_w[sel], b2x_wrap_w[sel]};
    s_cmd     = b2x_cmd_w[sel];
    s_addr    = b2x_addr_w[sel];
    s_row     = bank_row_w[sel];
    s_id      = b2x_id_w[sel];
    s_len     = b2x_len_w[sel];
  end

  typedef struct packed { logic [1:0] cmd; logic [AW-1:0] addr; } cmd_t;
  cmd_t       exp_q[$];
  cmd_t       sb_e;
  int         log_cyc[$];
  logic [1:0] log_cmd[$];
  int n_checks = 0, n_fail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every accepted command of the selected bank must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && s_req && s_xack) begin
      log_cyc.push_back(cyc);
      log_cmd.push_back(s_cmd);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got cmd=%0d addr=%h, expected no command", s_cmd, s_addr);
      end else begin
        sb_e = exp_q.pop_front();
        if ({s_cmd, s_addr} !== {sb_e.cmd, sb_e.addr}) begin
          n_fail++;
          $display("FAIL sb_cmd: got cmd=%0d addr=%h, expected cmd=%0d addr=%h",
                   s_cmd, s_addr, sb_e.cmd, sb_e.addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    r2b_req = 0; r2b_start = 0; r2b_last = 0; r2b_wrap = 0; r2b_write = 0; sdr_dma_last = 0;
    r2b_req_id = '0; r2b_raddr = '0; r2b_caddr = '0; r2b_len = '0;
    x2b_refresh = 0; x2b_pre_ok = 1; x2b_act_ok = 1; x2b_rdok = 1; x2b_wrok = 1; xfr_ok = 1;
    tras_delay = '0; trp_delay = '0; trcd_delay = '0; auto_ack = 1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    log_cyc.delete();
    log_cmd.delete();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    clear_logs();
  endtask

  task automatic expect_cmd(input logic [1:0] c, input logic [AW-1:0] a);
    exp_q.push_back({c, a});
  endtask

  task automatic send_req(input logic [RA_W-1:0] row, input logic [CA_W-1:0] col,
                          input logic wr, input logic dl, output int ack_cyc);
    bit got = 0;
    ack_cyc = -1;
    r2b_req = 1; r2b_raddr = row; r2b_caddr = col; r2b_write = wr; sdr_dma_last = dl;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (s_ack) begin
        got = 1;
        ack_cyc = cyc;
      end
      tick();
    end
    r2b_req = 0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL req_ack_timeout: b2r_ack=0 for 40 cycles, expected 1 (row %h)", row);
    end
  endtask

  task automatic drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      tick();
      i++;
    end
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d commands pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int ac;
    set_defaults(); do_reset(); sel = 0;
    r2b_req_id = 4'h9; r2b_len = 7'd33;
    @(negedge clk);
    n_checks++;
    if (s_id !== 4'h9 || s_len !== 7'd33) begin
      n_fail++; $display("FAIL idle_passthru: id=%h len=%0d, expected id=9 len=33", s_id, s_len);
    end
    tick();
    tras_delay = 4'd9;
    expect_cmd(OP_ACT, 13'h077); expect_cmd(OP_RD, 13'h003);
    send_req(13'h077, 13'h003, 0, 0, ac);
    drain("rst_open");
    // miss blocked in PRE by pre_ok=0, qualifiers latched
    x2b_pre_ok = 0;
    r2b_req_id = 4'h5; r2b_len = 7'd17; r2b_start = 1; r2b_last = 1; r2b_wrap = 0;
    send_req(13'h078, 13'h004, 0, 0, ac);
    r2b_req_id = 4'hA; r2b_len = 7'd2; r2b_start = 0; r2b_last = 0; r2b_wrap = 1;
    @(negedge clk);
    n_checks++;
    if (s_id !== 4'h5 || s_len !== 7'd17 || s_qual !== 3'b110) begin
      n_fail++;
      $display("FAIL latched_qual: id=%h len=%0d sl w=%b, expected id=5 len=17 slw=110", s_id, s_len, s_qual);
    end
    n_checks++;
    if (s_bv !== 1'b1 || s_req !== 1'b0) begin
      n_fail++; $display("FAIL pre_stall: bank_valid=%b b2x_req=%b, expected 1 0", s_bv, s_req);
    end
    tick();
    reset = 1;
    tick();
    reset = 0; x2b_pre_ok = 1;
    clear_logs();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (bank_valid_w[g] !== 1'b0) begin n_fail++; $display("FAIL rst_bank_valid[%0d]: %b, expected 0", g, bank_valid_w[g]); end
      n_checks++;
      if (bank_row_w[g] !== '0) begin n_fail++; $display("FAIL rst_bank_row[%0d]: %h, expected 0", g, bank_row_w[g]); end
      n_checks++;
      if (tras_ok_w[g] !== 1'b1) begin n_fail++; $display("FAIL rst_tras_ok[%0d]: %b, expected 1", g, tras_ok_w[g]); end
      n_checks++;
      if (b2x_req_w[g] !== 1'b0) begin n_fail++; $display("FAIL rst_b2x_req[%0d]: %b, expected 0", g, b2x_req_w[g]); end
      n_checks++;
      if (b2r_ack_w[g] !== 1'b0) begin n_fail++; $display("FAIL rst_b2r_ack[%0d]: %b, expected 0", g, b2r_ack_w[g]); end
    end
    tick();
  endtask

  task automatic test_first_act();
    int ac;
    set_defaults(); do_reset(); sel = 0;
    expect_cmd(OP_ACT, 13'h012); expect_cmd(OP_RD, 13'h040);
    send_req(13'h012, 13'h040, 0, 0, ac);
    drain("first_act");
    n_checks++;
    if (log_cyc.size() != 2 || log_cyc[0] != ac + 1 || log_cyc[1] != ac + 2) begin
      n_fail++; $display("FAIL first_act_timing: %0d cmds, act@+%0d, expected act@+1 rd@+2", log_cyc.size(), log_cyc[0] - ac);
    end
    n_checks++;
    if (s_bv !== 1'b1 || s_row !== 13'h012) begin
      n_fail++; $display("FAIL first_act_row: valid=%b row=%h, expected 1 012", s_bv, s_row);
    end
  endtask

  task automatic test_hit_miss();
    int ac;
    clear_logs();
    expect_cmd(OP_RD, 13'h041);
    send_req(13'h012, 13'h041, 0, 0, ac);
    drain("hit");
    n_checks++;
    if (log_cyc.size() != 1 || log_cyc[0] != ac + 1) begin
      n_fail++; $display("FAIL hit_latency: rd at ack+%0d, expected ack+1", log_cyc[0] - ac);
    end
    clear_logs();
    expect_cmd(OP_PRE, 13'h034); expect_cmd(OP_ACT, 13'h434); expect_cmd(OP_WR, 13'h042);
    send_req(13'h434, 13'h042, 1, 0, ac);
    drain("miss");
    n_checks++;
    if (s_bv !== 1'b1 || s_row !== 13'h434) begin
      n_fail++; $display("FAIL miss_row: valid=%b row=%h, expected 1 434", s_bv, s_row);
    end
  endtask

  task automatic test_tras();
    int ac1, ac2;
    set_defaults(); do_reset(); sel = 0;
    tras_delay = 4'd6; trp_delay = 4'd2;
    expect_cmd(OP_ACT, 13'h012); expect_cmd(OP_RD, 13'h010);
    expect_cmd(OP_PRE, 13'h056); expect_cmd(OP_ACT, 13'h056); expect_cmd(OP_RD, 13'h011);
    send_req(13'h012, 13'h010, 0, 0, ac1);
    send_req(13'h056, 13'h011, 0, 0, ac2);
    @(negedge clk);
    n_checks++;
    if (ac2 != log_cyc[0] + 2 || s_tras_ok !== 1'b0 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL tras_hold: miss ack at act+%0d tras_ok=%b req=%b, expected +2 0 0", ac2 - log_cyc[0], s_tras_ok, s_req);
    end
    tick();
    drain("tras");
    n_checks++;
    if (log_cyc.size() != 5 || log_cyc[2] != log_cyc[0] + 7) begin
      n_fail++; $display("FAIL tras_pre_time: pre at act+%0d, expected act+7", log_cyc[2] - log_cyc[0]);
    end
    n_checks++;
    if (log_cyc[3] != log_cyc[2] + 3 || log_cyc[4] != log_cyc[3] + 1) begin
      n_fail++; $display("FAIL trp_time: act at pre+%0d rd at act+%0d, expected 3 1", log_cyc[3] - log_cyc[2], log_cyc[4] - log_cyc[3]);
    end
  endtask

  task automatic test_closed_page();
    int ac;
    set_defaults(); do_reset(); sel = 1;
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      expect_cmd(OP_ACT, 13'h020); expect_cmd(OP_RD, 13'(5 + k)); expect_cmd(OP_PRE, 13'h020);
      send_req(13'h020, 13'(5 + k), 0, 0, ac);
      drain("closed_page");
      n_checks++;
      if (s_bv !== 1'b0 || log_cmd.size() != 3) begin
        n_fail++; $display("FAIL closed_page_%0d: valid=%b cmds=%0d, expected 0 3", k, s_bv, log_cmd.size());
      end
    end
  endtask

  task automatic test_dma_last();
    int ac;
    set_defaults(); do_reset(); sel = 0;
    expect_cmd(OP_ACT, 13'h009); expect_cmd(OP_RD, 13'h001);
    send_req(13'h009, 13'h001, 0, 0, ac);
    drain("dma_open");
    expect_cmd(OP_RD, 13'h002); expect_cmd(OP_PRE, 13'h009);
    send_req(13'h009, 13'h002, 0, 1, ac);
    drain("dma_last");
    n_checks++;
    if (s_bv !== 1'b0) begin n_fail++; $display("FAIL dma_last_close: valid=%b, expected 0", s_bv); end
    expect_cmd(OP_ACT, 13'h009); expect_cmd(OP_WR, 13'h003);
    send_req(13'h009, 13'h003, 1, 0, ac);
    drain("dma_reopen");
  endtask

  task automatic test_idle_close();
    int ac, r;
    set_defaults(); do_reset(); sel = 2;
    expect_cmd(OP_ACT, 13'h030); expect_cmd(OP_RD, 13'h007); expect_cmd(OP_PRE, 13'h030);
    send_req(13'h030, 13'h007, 0, 0, ac);
    drain("idle_close");
    n_checks++;
    if (log_cyc.size() != 3 || log_cyc[2] != log_cyc[1] + 9 || s_bv !== 1'b0) begin
      n_fail++; $display("FAIL idle_close_time: pre at rd+%0d valid=%b, expected rd+9 0", log_cyc[2] - log_cyc[1], s_bv);
    end
    clear_logs();
    expect_cmd(OP_ACT, 13'h030); expect_cmd(OP_RD, 13'h008);
    send_req(13'h030, 13'h008, 0, 0, ac);
    for (int i = 0; i < 20 && log_cyc.size() < 2; i++) tick();
    r = (log_cyc.size() >= 2) ? log_cyc[1] : cyc;
    while (cyc < r + 8) tick();
    expect_cmd(OP_RD, 13'h009); expect_cmd(OP_PRE, 13'h030);
    send_req(13'h030, 13'h009, 0, 0, ac);
    drain("idle_race");
    n_checks++;
    if (ac != r + 8 || log_cyc.size() != 4 || log_cyc[2] != ac + 1) begin
      n_fail++; $display("FAIL idle_race_hit: ack at rd+%0d rd2 at ack+%0d, expected 8 1", ac - r, log_cyc[2] - ac);
    end
    n_checks++;
    if (log_cyc[3] != log_cyc[2] + 9) begin
      n_fail++; $display("FAIL idle_restart: pre at rd+%0d, expected rd+9", log_cyc[3] - log_cyc[2]);
    end
  endtask

  task automatic test_refresh();
    int ac;
    set_defaults(); do_reset(); sel = 0;
    trcd_delay = 4'd3;
    expect_cmd(OP_ACT, 13'h012); expect_cmd(OP_RD, 13'h001);
    send_req(13'h012, 13'h001, 0, 0, ac);
    drain("ref_open");
    n_checks++;
    if (log_cyc[1] != log_cyc[0] + 4) begin
      n_fail++; $display("FAIL trcd_time: rd at act+%0d, expected act+4", log_cyc[1] - log_cyc[0]);
    end
    clear_logs();
    xfr_ok = 0;
    expect_cmd(OP_ACT, 13'h012); expect_cmd(OP_RD, 13'h002);
    send_req(13'h012, 13'h002, 0, 0, ac);
    tick();
    x2b_refresh = 1;
    tick();
    x2b_refresh = 0; xfr_ok = 1;
    @(negedge clk);
    n_checks++;
    if (s_bv !== 1'b0) begin n_fail++; $display("FAIL ref_xfr_valid: %b, expected 0", s_bv); end
    tick();
    drain("ref_xfr");
    n_checks++;
    if (s_bv !== 1'b1 || s_row !== 13'h012) begin
      n_fail++; $display("FAIL ref_reopen: valid=%b row=%h, expected 1 012", s_bv, s_row);
    end
    clear_logs();
    expect_cmd(OP_ACT, 13'h012); expect_cmd(OP_RD, 13'h003);
    x2b_refresh = 1;
    send_req(13'h012, 13'h003, 0, 0, ac);
    x2b_refresh = 0;
    drain("ref_idle");
    n_checks++;
    if (log_cyc.size() != 2 || log_cyc[1] != log_cyc[0] + 4) begin
      n_fail++; $display("FAIL ref_idle_seq: %0d cmds, expected ACT then RD 4 cycles later", log_cyc.size());
    end
  endtask

  initial begin
    sel = 0;
    reset = 1;
    set_defaults();
    test_reset();
    test_first_act();
    test_hit_miss();
    test_tras();
    test_closed_page();
    test_dma_last();
    test_idle_close();
    test_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200us, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdrc_bank_fsm_p.md
SDRC_BANK_FSM_P -- requirements
Module: sdrc_bank_fsm_p

Interface
REQ-001 Parameter RA_W, 13, row address width.
REQ-002 Parameter CA_W, 13, column address width.
REQ-003 Parameter ID_W, 4, request ID width.
REQ-004 Parameter LEN_W, 7, transfer length width.
REQ-005 Parameter TW, 4, timing counter width.
REQ-006 Parameter PAGE_MODE, 0, 0 = open-page, 1 = closed-page (precharge after every transfer).
REQ-007 Parameter IDLE_CLOSE, 0, idle cycles before auto-precharge of an open row; 0 disables.
REQ-008 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 Port reset, input, 1, synchronous active-high reset.
REQ-010 Ports r2b_req / r2b_start / r2b_last / r2b_wrap / r2b_write / sdr_dma_last, input, 1 each, request qualifiers from the request generator.
REQ-011 Ports r2b_req_id (ID_W), r2b_raddr (RA_W), r2b_caddr (CA_W), r2b_len (LEN_W), input, request fields.
REQ-012 Port b2r_ack, output, 1, request accepted and latched this cycle.
REQ-013 Ports b2x_req / b2x_start / b2x_last / b2x_wrap, output, 1 each, command request and qualifiers to the transfer controller.
REQ-014 Ports b2x_id (ID_W), b2x_len (LEN_W), b2x_cmd (2, OP_PRE/OP_ACT/OP_RD/OP_WR per sdrc_define), b2x_addr (max(RA_W,CA_W)), output.
REQ-015 Port x2b_ack, input, 1, command taken; valid only while b2x_req=1.
REQ-016 Ports x2b_refresh / x2b_pre_ok / x2b_act_ok / x2b_rdok / x2b_wrok / xfr_ok, input, 1 each, controller status.
REQ-017 Ports tras_delay / trp_delay / trcd_delay, input, TW each, timing in clk cycles.
REQ-018 Ports tras_ok (1), bank_valid (1), bank_row (RA_W), output, bank status.

Function
REQ-019 States: IDLE, PRE, ACT, XFR, CLOSE.
REQ-020 page_hit = bank_valid & (r2b_raddr == bank_row).
REQ-021 IDLE with r2b_req: b2r_ack=1 combinationally, all fields latched; next state XFR on hit, PRE on miss with bank_valid=1, ACT on miss with bank_valid=0 (no redundant precharge).
REQ-022 PRE: b2x_req = tras_ok & x2b_pre_ok & (timer==0), cmd OP_PRE, addr = latched row with bit 10 forced 0; on x2b_ack load timer with trp_delay, clear bank_valid, go ACT.
REQ-023 ACT: b2x_req = (timer==0) & x2b_act_ok, cmd OP_ACT, addr = latched row; on x2b_ack load timer with trcd_delay, load tras counter with tras_delay, set bank_valid, bank_row = latched row, go XFR.
REQ-024 XFR: b2x_req = (timer==0) & xfr_ok & (write ? x2b_wrok : x2b_rdok), cmd OP_WR/OP_RD, addr = latched column; on x2b_ack go CLOSE if sdr_dma_last latched or PAGE_MODE=1, else IDLE.
REQ-025 CLOSE: same request/addr rules as PRE; on x2b_ack load timer with trp_delay, clear bank_valid, go IDLE.
REQ-026 IDLE with no request, bank_valid=1, IDLE_CLOSE>0: idle counter increments; on reaching IDLE_CLOSE go CLOSE; counter clears on any request or state exit.
REQ-027 x2b_refresh clears bank_valid same cycle; in XFR forces ACT; in PRE forces ACT; in CLOSE forces IDLE; in IDLE with request, treat as miss with bank_valid=0.
REQ-028 r2b_req arriving in the same cycle IDLE_CLOSE expires: request wins, no CLOSE.
REQ-029 tras counter decrements to 0 and saturates; tras_ok = (counter==0); timer decrements to 0 and saturates.
REQ-030 b2x_start/last/id/len/wrap show r2b_* values in IDLE, latched values otherwise.
REQ-031 Zero delays are legal: the dependent command may be requested the cycle after ack.
REQ-032 b2x_req never asserts in IDLE; b2r_ack never asserts outside IDLE.

Reset
REQ-033 reset=1 at a clock edge: state IDLE, bank_valid=0, bank_row=0, counters 0, tras_ok=1, b2x_req=0, b2r_ack=0, latched fields 0; aborts any state mid-operation.

Verification
REQ-034 Reset, read row 0x12 (bank invalid) -> IDLE->ACT->XFR, no OP_PRE issued, bank_row=0x12.
REQ-035 Open row 0x12, read row 0x12 -> b2r_ack then OP_RD immediately; read row 0x34 -> OP_PRE, addr bit10=0, then OP_ACT 0x34.
REQ-036 tras_delay=6, miss issued 2 cycles after ACT ack with pre_ok=1 -> OP_PRE b2x_req held 0 until tras_ok=1.
REQ-037 PAGE_MODE=1, two reads same row -> each followed by OP_PRE; second read sees bank_valid=0, goes ACT.
REQ-038 IDLE_CLOSE=8, row open, no requests -> CLOSE after 8 idle cycles; request on cycle 8 -> served as hit instead.
REQ-039 x2b_refresh pulse while in XFR -> bank_valid=0, re-ACT of latched row before OP_RD.
